// File: rtl/pipe_pkg.sv
// Shared opcode constants, bubble encoding and instruction field slices
// for the 5-stage core pipeline tracker.
package pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_NOP   = 6'b111111;

    localparam logic [31:0] NOP_WORD = {OP_NOP, 26'd0};

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int TGT_HI = 25;
    localparam int TGT_LO = 0;

endpackage

// File: rtl/stage_reg.sv
// Generic pipeline register: flush loads RESET_VAL and beats en.
// Ports: clk, rst (sync, active-high), en, flush, d -> q.
module stage_reg #(
    parameter int              WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)        q <= RESET_VAL;
        else if (flush) q <= RESET_VAL;
        else if (en)    q <= d;
    end

endmodule

// File: rtl/instr_pipe_tracker.sv
// PC and per-stage instruction registers with stall/flush handling and
// statistics. Ports: clk, rst, hazard controls, imem_instr, redirect in;
// pc, four stage words and stall/bubble/retire counters out.
module instr_pipe_tracker #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = pipe_pkg::NOP_WORD,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pcenable,
    input  logic             idifenable,
    input  logic             ifidNOP,
    input  logic             idexNOP,
    input  logic             exmemNOP,
    input  logic [31:0]      imem_instr,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      pc,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      id_ex_instr,
    output logic [31:0]      ex_mem_instr,
    output logic [31:0]      mem_wb_instr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    import pipe_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0] if_id_pc;
    logic        is_j;
    logic        jcarry;
    logic [3:0]  jhi;
    logic [31:0] jtarget;

    // Upper nibble of (if_id_pc+4) without a full 32-bit adder.
    assign jcarry  = (if_id_pc[27:0] >= 28'hFFF_FFFC);
    assign jhi     = if_id_pc[31:28] + {3'b000, jcarry};
    assign is_j    = (if_id_instr[OPC_HI:OPC_LO] == OP_J);
    assign jtarget = {jhi, if_id_instr[TGT_HI:TGT_LO], 2'b00};

    always_ff @(posedge clk) begin
        if (rst)                 pc <= RESET_PC;
        else if (redirect_valid) pc <= redirect_pc;
        else if (is_j)           pc <= jtarget;
        else if (pcenable)       pc <= pc + 32'd4;
    end

    stage_reg #(.WIDTH(32), .RESET_VAL(NOP_WORD)) u_ifid (
        .clk(clk), .rst(rst), .en(idifenable), .flush(ifidNOP),
        .d(imem_instr), .q(if_id_instr)
    );

    // The fetch PC only follows a real load; a flush leaves it alone.
    stage_reg #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_ifid_pc (
        .clk(clk), .rst(rst), .en(idifenable & ~ifidNOP), .flush(1'b0),
        .d(pc), .q(if_id_pc)
    );

    stage_reg #(.WIDTH(32), .RESET_VAL(NOP_WORD)) u_idex (
        .clk(clk), .rst(rst), .en(1'b1), .flush(idexNOP),
        .d(if_id_instr), .q(id_ex_instr)
    );

    stage_reg #(.WIDTH(32), .RESET_VAL(NOP_WORD)) u_exmem (
        .clk(clk), .rst(rst), .en(1'b1), .flush(exmemNOP),
        .d(id_ex_instr), .q(ex_mem_instr)
    );

    stage_reg #(.WIDTH(32), .RESET_VAL(NOP_WORD)) u_memwb (
        .clk(clk), .rst(rst), .en(1'b1), .flush(1'b0),
        .d(ex_mem_instr), .q(mem_wb_instr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            retire_cnt <= '0;
        end else begin
            if (!pcenable && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_ONE;
            if ((ifidNOP | idexNOP | exmemNOP) && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + CNT_ONE;
            if (mem_wb_instr[OPC_HI:OPC_LO] != OP_NOP && retire_cnt != '1)
                retire_cnt <= retire_cnt + CNT_ONE;
        end
    end

endmodule
